pipe_stage_hs: RTL and testbench
================================

// Module: pipe_stage_hs
// PURPOSE
//  Generic parametrised pipeline stage register with valid/ready handshake, stall and flush.
//  Successor to the fixed per-stage latches between IF/ID/EX/MEM/WB:
//   - one instance per stage boundary, carrying a packed control+data bus;
//   - provides back-pressure (stall) and bubble insertion (flush) that the fixed latches lack.
//  Also counts stall cycles for performance analysis.
// PARAMETERS
//  DATA_W    32  width of the packed payload (PC+4, instruction, control fields, ...)
//  RESET_VAL 0   payload value after reset or flush (all-zero = MIPS NOP bubble)
//  CNT_W     16  width of the saturating stall counter
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  reset      in   1       asynchronous, active-low reset
//  flush      in   1       synchronous flush; squashes every held beat and the incoming beat
//  in_valid   in   1       upstream beat present
//  in_ready   out  1       stage can accept a beat this cycle
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       downstream beat present
//  out_ready  in   1       downstream accepts the beat this cycle
//  out_data   out  DATA_W  downstream payload
//  stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - Reset (reset=0, async, no clock needed):
//    out_valid=0, out_data=RESET_VAL, stall_cnt=0, skid entry empty.
//  - Transfer: in side on in_valid&&in_ready; out side on out_valid&&out_ready; both evaluated at the same edge.
//  - Latency 1 cycle: a beat accepted at edge N appears on out_data/out_valid after edge N.
//  - Throughput 1 beat/cycle when out_ready=1 continuously.
//  - Hold: while out_valid=1 and out_ready=0, out_data/out_valid stay stable; a beat is never dropped or duplicated.
//  - Drain: out beat consumed and no in beat accepted -> out_valid=0 next cycle; out_data retains its last value.
//  - Flush: at the edge where flush=1:
//    out_valid<=0, out_data<=RESET_VAL, skid entry emptied.
//    The incoming beat is discarded even if in_valid&&in_ready; flush wins over every simultaneous transfer.
//  - in_ready during flush follows its normal rule; beats offered then are consumed and dropped.
//  - stall_cnt: +1 on each edge where out_valid&&!out_ready (sampled before update).
//    Saturates at 2^CNT_W-1; cleared only by reset; unaffected by flush.
//  - Reset asserted mid-stall or mid-flush: all state returns to reset values immediately.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN undefined:
//   - single register;
//   - in_ready = !out_valid || out_ready (combinational path from out_ready);
//   - max occupancy 1.
//  PIPE_STAGE_SKID_EN defined:
//   - extra skid entry; in_ready is a flop = skid empty (no combinational out_ready->in_ready path).
//   - Beat arriving while main stalled goes to the skid; in_ready=0 from next cycle.
//   - On out_ready with skid full: skid moves to main, out_valid stays 1, skid empties, in_ready=1 next cycle.
//   - Ordering strictly FIFO; max occupancy 2; full throughput preserved.
// STRUCTURE
//  - Package pipe_pkg:
//    default DATA_W/CNT_W constants, NOP_WORD (=32'h0), stall-counter saturation helper function.
//  - Sub-module pipe_skid_buf (one-entry skid, data+valid, flush input):
//    instantiated only under PIPE_STAGE_SKID_EN.
//  - Top holds the main register, handshake logic and stall counter.
// TESTING
//  - Reset: drive reset=0 mid-stall with out_valid=1, data 0xA5
//    -> out_valid=0, out_data=0, stall_cnt=0 before the next clk edge.
//  - Streaming: beats 0x1,0x2,0x3 on consecutive cycles, out_ready=1
//    -> 0x1,0x2,0x3 emitted one cycle later, no gaps, in_ready=1 throughout.
//  - Stall: out_valid=1 with 0xA5, out_ready=0 for 3 cycles, then 0x5A offered
//    -> 0xA5 stable and stall_cnt=3.
//    No-skid: in_ready=0. Skid: 0x5A accepted once, then in_ready=0.
//    On release the outputs are 0xA5 then 0x5A.
//  - Flush: flush=1 with in_valid=1, in_data=0x77, main holding 0x10 (skid build: skid holding 0x11)
//    -> next cycle out_valid=0, out_data=0; 0x10/0x11/0x77 never appear downstream.
//  - Simultaneous: out_ready=1 and in_valid=1 on a full single stage
//    -> old beat consumed, new beat loaded the same edge, out_valid stays 1.
//  - Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15 and holds; a flush leaves it at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_stage_hs pipeline register family.
package pipe_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_CNT_W  = 16;
  localparam logic [31:0] NOP_WORD       = 32'h0;

  // Saturating increment; callers widen their counter to 32 bits (CNT_W <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
    return (cnt >= max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer (data + valid) with synchronous flush, used by pipe_stage_hs
// when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(NOP_WORD),
  parameter int unsigned       CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;

  assign in_fire = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic skid_load;
  logic skid_pop;

  // A beat accepted while main is stalled parks in the skid; skid is only ever
  // full while main is full, so out_ready alone is enough to pop it.
  assign skid_load = in_fire && main_valid_q && !out_ready;
  assign skid_pop  = skid_valid && out_ready;
  assign in_ready  = !skid_valid;

  pipe_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .load      (skid_load),
    .load_data (in_data),
    .pop       (skid_pop),
    .valid     (skid_valid),
    .data      (skid_data)
  );
`else
  assign skid_valid = 1'b0;
  assign skid_data  = RESET_VAL;
  assign in_ready   = !main_valid_q || out_ready;
`endif

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = RESET_VAL;
    end else if (!main_valid_q || out_ready) begin
      // Main is free this edge; older skid beat has priority over the incoming one.
      if (skid_valid) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready) begin
      stall_cnt_d = CNT_W'(sat_inc(32'(stall_cnt_q), 32'(CntMax)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= RESET_VAL;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed self-checking bench for pipe_stage_hs; expectations adapt to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_hs;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  stall_cnt;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  pipe_stage_hs #(
    .DATA_W    (32),
    .RESET_VAL (32'h0),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // Streaming 1,2,3 with out_ready held high
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", out_data, 32'(i));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data_kept", out_data, 32'h3);
    chk("stream_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // Stall: A5 held for three cycles, then 5A offered
    drive(1'b1, 32'hA5, 1'b0, 1'b0);
    tick();
    chk("stall_load", out_data, 32'hA5);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick(); tick(); tick();
    exp_cnt = 3;
    chk("stall_hold_data", out_data, 32'hA5);
    chk("stall_hold_valid", 32'(out_valid), 32'd1);
    chk("stall_cnt3", 32'(stall_cnt), 32'(exp_cnt));
    drive(1'b1, 32'h5A, 1'b0, 1'b0);
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("stall_skid_ready", 32'(in_ready), 32'd1);
`else
    chk("stall_ready_low", 32'(in_ready), 32'd0);
`endif
    tick();
    exp_cnt = 4;
    chk("stall_in_ready_after", 32'(in_ready), 32'd0);
    chk("stall_data_a5", out_data, 32'hA5);
    tick();
    exp_cnt = 5;
    chk("stall_cnt5", 32'(stall_cnt), 32'(exp_cnt));
`ifdef PIPE_STAGE_SKID_EN
    drive(1'b0, 32'h0, 1'b1, 1'b0);
`else
    drive(1'b1, 32'h5A, 1'b1, 1'b0);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
`endif
    chk("release_first", out_data, 32'hA5);
    tick();
    chk("release_second", out_data, 32'h5A);
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_ready_back", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("release_drained", 32'(out_valid), 32'd0);
    chk("release_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // Flush with main (and skid) occupied and 77 offered
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    chk("flush_setup_main", out_data, 32'h10);
`ifdef PIPE_STAGE_SKID_EN
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    tick();
    exp_cnt++;
    chk("flush_setup_skid_full", 32'(in_ready), 32'd0);
`endif
    drive(1'b1, 32'h77, 1'b0, 1'b1);
    tick();
    exp_cnt++;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_data", out_data, 32'h0);
    chk("flush_cnt_kept", 32'(stall_cnt), 32'(exp_cnt));
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_leak_valid", 32'(out_valid), 32'd0);
      chk("flush_no_leak_data", out_data, 32'h0);
    end

    // Simultaneous consume and load on a full stage
    drive(1'b1, 32'h21, 1'b0, 1'b0);
    tick();
    chk("simul_setup", out_data, 32'h21);
    drive(1'b1, 32'h22, 1'b1, 1'b0);
    #1;
    chk("simul_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("simul_valid", 32'(out_valid), 32'd1);
    chk("simul_data", out_data, 32'h22);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("simul_drain", 32'(out_valid), 32'd0);
    chk("simul_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // Saturation: 20 stall cycles on a 4-bit counter
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt15", 32'(stall_cnt), 32'd15);
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'd15);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("sat_after_flush", 32'(stall_cnt), 32'd15);
    chk("sat_flush_valid", 32'(out_valid), 32'd0);

    // Async reset in the middle of a stall
    drive(1'b1, 32'hA5, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("areset_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_valid", 32'(out_valid), 32'd0);
    chk("areset_data", out_data, 32'h0);
    chk("areset_cnt", 32'(stall_cnt), 32'd0);
    chk("areset_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
